// File: rtl/miner_sweep_ctrl_if.sv
// Bundle of sweep request/result signals between a sweep client and miner_sweep_ctrl.
// Also carries the controller state and lane-run vector for observation.
interface miner_sweep_ctrl_if #(
    parameter int LANES = 4
);
    // Handshake: start is a one-cycle request honoured only while dbg_state reads
    // IDLE or DONE, and every other request input is captured with it. The result
    // fields are valid from the first cycle dbg_state reads DONE until the next
    // accepted start. abort is a level; it is honoured only in LOAD, RUN and CHECK.
    logic             start;
    logic             abort;
    logic [639:0]     header;
    logic [31:0]      nonce_start;
    logic [31:0]      nonce_end;
    logic [255:0]     target;
    logic             busy;
    logic             found;
    logic             exhausted;
    logic [31:0]      found_nonce;
    logic [255:0]     found_hash;
    logic [31:0]      attempts;
    logic [2:0]       dbg_state;
    logic [LANES-1:0] dbg_lane_run;

    modport master (
        output start, abort, header, nonce_start, nonce_end, target,
        input  busy, found, exhausted, found_nonce, found_hash, attempts,
        input  dbg_state, dbg_lane_run
    );

    modport slave (
        input  start, abort, header, nonce_start, nonce_end, target,
        output busy, found, exhausted, found_nonce, found_hash, attempts,
        output dbg_state, dbg_lane_run
    );
endinterface

// File: rtl/miner_sweep_ctrl.sv
// Nonce-sweep engine: LANES SHA-256 miners hash consecutive nonces per round until a hit or the range ends.
// Optional MINER_SWEEP_DOUBLE_HASH_EN chains a second miner per lane over {384'b0, first_hash}.
module miner (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic [639:0] block,
    output logic [255:0] hash,
    output logic         done
);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] H_INIT =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    logic [31:0]  w [16];
    logic [255:0] v, hs, v_next, hs_next;
    logic [31:0]  t1, t2, w_new;
    logic [511:0] blk1;
    logic [5:0]   rnd;
    logic         second, started;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // An 80-byte message pads to exactly two blocks; the second carries the tail and length.
    assign blk1 = {block[127:0], 1'b1, 319'b0, 64'd640};

    always_comb begin
        logic [31:0] a, b, c, d, e, f, g, h;
        {a, b, c, d, e, f, g, h} = v;
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[rnd] + w[0];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        v_next = {t1 + t2, a, b, c, d + t1, e, f, g};
        w_new = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10)) + w[9]
              + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[0];
        hs_next = '0;
        for (int j = 0; j < 8; j++) hs_next[j*32 +: 32] = hs[j*32 +: 32] + v_next[j*32 +: 32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 16; j++) w[j] <= '0;
            v       <= '0;
            hs      <= '0;
            rnd     <= '0;
            second  <= 1'b0;
            started <= 1'b0;
            done    <= 1'b0;
            hash    <= '0;
        end else if (hold) begin
            started <= 1'b0;
            done    <= 1'b0;
        end else if (!started) begin
            for (int j = 0; j < 16; j++) w[j] <= block[639-32*j -: 32];
            v       <= H_INIT;
            hs      <= H_INIT;
            rnd     <= '0;
            second  <= 1'b0;
            started <= 1'b1;
        end else if (!done) begin
            for (int j = 0; j < 15; j++) w[j] <= w[j+1];
            w[15] <= w_new;
            v     <= v_next;
            rnd   <= rnd + 6'd1;
            if (rnd == 6'd63) begin
                if (!second) begin
                    for (int j = 0; j < 16; j++) w[j] <= blk1[511-32*j -: 32];
                    v      <= hs_next;
                    hs     <= hs_next;
                    second <= 1'b1;
                end else begin
                    hash <= hs_next;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

module miner_sweep_ctrl #(
    parameter int LANES     = 4,
    parameter int NONCE_LSB = 0
) (
    input logic               clk,
    input logic               rst,
    miner_sweep_ctrl_if.slave sif
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, CHECK = 3'd3, DONE = 3'd4} state_t;

    state_t                  state;
    logic [639:0]            hdr_q;
    logic [31:0]             end_q, base_q;
    logic [255:0]            tgt_q;
    logic                    busy_q, found_q, exhausted_q;
    logic [31:0]             found_nonce_q, attempts_q;
    logic [255:0]            found_hash_q;
    logic [LANES-1:0]        lane_hold, lane_en, lane_done, lane_hit;
    logic [LANES-1:0][255:0] lane_hash;
    logic [6:0]              en_cnt;
    logic                    win_any, round_end;
    logic [31:0]             win_nonce;
    logic [255:0]            win_hash;
    logic [32:0]             att_sum;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [32:0]  nonce_wide;
        logic [639:0] blk;
        assign nonce_wide = {1'b0, base_q} + 33'(i);
        assign lane_en[i] = nonce_wide <= {1'b0, end_q};
        always_comb begin
            blk = hdr_q;
            blk[NONCE_LSB +: 32] = nonce_wide[31:0];
        end
`ifdef MINER_SWEEP_DOUBLE_HASH_EN
        logic [255:0] h0;
        logic         d0;
        miner u_stage0 (.clk, .rst_n(rst), .hold(lane_hold[i]), .block(blk), .hash(h0), .done(d0));
        miner u_stage1 (.clk, .rst_n(rst), .hold(lane_hold[i] | ~d0), .block({384'b0, h0}),
                        .hash(lane_hash[i]), .done(lane_done[i]));
`else
        miner u_stage0 (.clk, .rst_n(rst), .hold(lane_hold[i]), .block(blk),
                        .hash(lane_hash[i]), .done(lane_done[i]));
`endif
        assign lane_hit[i] = lane_en[i] && (lane_hash[i] < tgt_q);
    end

    // Scanning high to low leaves the lowest-index hitting lane as the winner.
    always_comb begin
        win_any   = 1'b0;
        win_nonce = '0;
        win_hash  = '0;
        en_cnt    = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_hit[i]) begin
                win_any   = 1'b1;
                win_nonce = base_q + 32'(i);
                win_hash  = lane_hash[i];
            end
        end
        for (int i = 0; i < LANES; i++) en_cnt = en_cnt + 7'(lane_en[i]);
    end

    assign round_end = ({1'b0, base_q} + 33'(LANES)) > {1'b0, end_q};
    assign att_sum   = {1'b0, attempts_q} + 33'(en_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            hdr_q         <= '0;
            end_q         <= '0;
            base_q        <= '0;
            tgt_q         <= '0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            attempts_q    <= '0;
            lane_hold     <= '1;
        end else if (sif.abort && (state == LOAD || state == RUN || state == CHECK)) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            lane_hold <= '1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (sif.start) begin
                        hdr_q      <= sif.header;
                        end_q      <= sif.nonce_end;
                        base_q     <= sif.nonce_start;
                        tgt_q      <= sif.target;
                        found_q    <= 1'b0;
                        attempts_q <= '0;
                        lane_hold  <= '1;
                        if (sif.nonce_start > sif.nonce_end) begin
                            exhausted_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state       <= DONE;
                        end else begin
                            exhausted_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state       <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    lane_hold <= ~lane_en;
                    state     <= RUN;
                end
                RUN: begin
                    if (&(lane_done | ~lane_en)) begin
                        lane_hold <= '1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    attempts_q <= att_sum[32] ? '1 : att_sum[31:0];
                    if (win_any) begin
                        found_q       <= 1'b1;
                        found_nonce_q <= win_nonce;
                        found_hash_q  <= win_hash;
                        busy_q        <= 1'b0;
                        state         <= DONE;
                    end else if (round_end) begin
                        exhausted_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= DONE;
                    end else begin
                        base_q <= base_q + 32'(LANES);
                        state  <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sif.busy         = busy_q;
    assign sif.found        = found_q;
    assign sif.exhausted    = exhausted_q;
    assign sif.found_nonce  = found_nonce_q;
    assign sif.found_hash   = found_hash_q;
    assign sif.attempts     = attempts_q;
    assign sif.dbg_state    = state;
    assign sif.dbg_lane_run = ~lane_hold;
endmodule

// File: tb/tb_miner_sweep_ctrl.sv
// Bench for miner_sweep_ctrl: SHA-256 reference, sweep model, expected queue and DONE-triggered monitor.
module tb_miner_sweep_ctrl;
    localparam int LANES     = 4;
    localparam int NONCE_LSB = 0;
    localparam int W         = 322;
    localparam int BUDGET    = 3000;
    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd2, S_DONE = 3'd4;
    localparam logic [639:0] GENESIS = {32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    miner_sweep_ctrl_if #(.LANES(LANES)) sif ();
    miner_sweep_ctrl #(.LANES(LANES), .NONCE_LSB(NONCE_LSB)) dut (.clk(clk), .rst(rst), .sif(sif));

    int               n_checks = 0;
    int               n_pass   = 0;
    logic [W-1:0]     exp_q[$];
    logic [31:0]      k_tab [64];
    logic [255:0]     h0_init;

    // ---------------- reference SHA-256 ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Round constants and initial hash derived from prime roots rather than copied.
    task automatic init_constants();
        int p = 2;
        int cnt = 0;
        while (cnt < 64) begin
            bit is_prime = 1'b1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) is_prime = 1'b0;
            if (is_prime) begin
                if (cnt < 8) h0_init[255-32*cnt -: 32] = 32'(longint'($floor($sqrt(real'(p)) * 4294967296.0)));
                k_tab[cnt] = 32'(longint'($floor($pow(real'(p), 1.0 / 3.0) * 4294967296.0)));
                cnt++;
            end
            p++;
        end
    endtask

    function automatic logic [255:0] compress(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hv;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        r = {a, b, c, d, e, f, g, h};
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = r[j*32 +: 32] + hv[j*32 +: 32];
        return r;
    endfunction

    function automatic logic [255:0] sha640(input logic [639:0] m);
        logic [1023:0] padded;
        padded = {m, 1'b1, 319'b0, 64'd640};
        return compress(compress(h0_init, padded[1023:512]), padded[511:0]);
    endfunction

    function automatic logic [255:0] nonce_hash(input logic [639:0] hdr, input logic [31:0] nonce);
        logic [639:0] m;
        logic [255:0] r;
        m = hdr;
        m[NONCE_LSB +: 32] = nonce;
        r = sha640(m);
`ifdef MINER_SWEEP_DOUBLE_HASH_EN
        r = sha640({384'b0, r});
`endif
        return r;
    endfunction

    // Sweep outcome: first nonce in range below target; attempts cover every round up to the hit.
    function automatic logic [W-1:0] model(input logic [639:0] hdr, input logic [31:0] s, e,
                                           input logic [255:0] tgt);
        logic         hit = 1'b0;
        logic [31:0]  hit_nonce = '0;
        logic [255:0] hit_hash = '0;
        logic [255:0] h;
        longint       span, att;
        if (s > e) return {1'b0, 1'b1, 32'd0, 256'd0, 32'd0};
        span = longint'(e) - longint'(s) + 1;
        for (longint n = longint'(s); n <= longint'(e); n++) begin
            if (!hit) begin
                h = nonce_hash(hdr, 32'(n));
                if (h < tgt) begin
                    hit = 1'b1;
                    hit_nonce = 32'(n);
                    hit_hash = h;
                end
            end
        end
        att = span;
        if (hit) begin
            att = ((longint'(hit_nonce) - longint'(s)) / LANES + 1) * LANES;
            if (att > span) att = span;
        end
        return {hit, ~hit, hit_nonce, hit_hash, 32'(att)};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic             armed = 1'b0;
    int               sweep_cycles = 0;
    int               done_cnt = 0;
    logic [LANES-1:0] lanes_ever = '0;
    logic [LANES-1:0] last_run = '0;
    logic [W-1:0]     exp_w;

    always @(negedge clk) begin
        if (!rst) begin
            armed = 1'b0;
        end else begin
            if (armed) begin
                sweep_cycles++;
                lanes_ever = lanes_ever | sif.dbg_lane_run;
                if (sif.dbg_state == S_RUN) last_run = sif.dbg_lane_run;
                if (sif.dbg_state == S_DONE) begin
                    armed = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_done: sweep finished with no expected entry");
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("found", 256'(sif.found), 256'(exp_w[321]));
                        check("exhausted", 256'(sif.exhausted), 256'(exp_w[320]));
                        check("attempts", 256'(sif.attempts), 256'(exp_w[31:0]));
                        check("busy_done", 256'(sif.busy), 256'd0);
                        if (exp_w[321]) begin
                            check("found_nonce", 256'(sif.found_nonce), 256'(exp_w[319:288]));
                            check("found_hash", sif.found_hash, exp_w[287:32]);
                        end
                    end
                    done_cnt++;
                end else if (sif.dbg_state == S_IDLE) begin
                    armed = 1'b0;
                end
            end
            if (!armed && sif.start && (sif.dbg_state == S_IDLE || sif.dbg_state == S_DONE)) begin
                armed = 1'b1;
                sweep_cycles = 0;
                lanes_ever = '0;
                last_run = '0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic pulse_start(input logic [639:0] hdr, input logic [31:0] s, e, input logic [255:0] tgt);
        @(posedge clk); #1;
        sif.header = hdr;
        sif.nonce_start = s;
        sif.nonce_end = e;
        sif.target = tgt;
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
    endtask

    task automatic wait_done(input int cnt);
        int cyc = 0;
        while (done_cnt < cnt && cyc < BUDGET) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (done_cnt < cnt) begin
            n_checks++;
            $display("FAIL sweep_timeout: done count %0d required %0d", done_cnt, cnt);
            exp_q.delete();
        end
    endtask

    task automatic wait_state(input logic [2:0] st);
        int cyc = 0;
        while (sif.dbg_state != st && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (sif.dbg_state != st) begin
            n_checks++;
            $display("FAIL state_timeout: state %0d required %0d", sif.dbg_state, st);
        end
    endtask

    task automatic run_sweep(input logic [639:0] hdr, input logic [31:0] s, e, input logic [255:0] tgt);
        int want;
        exp_q.push_back(model(hdr, s, e, tgt));
        want = done_cnt + 1;
        pulse_start(hdr, s, e, tgt);
        wait_done(want);
    endtask

    function automatic logic [639:0] rand_header();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand_target();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 3))
            0: r = '1;
            1: r = '0;
            2: r = r >> 1;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [255:0] tgt;
        logic [31:0]  s, e;
        logic [32:0]  e_wide;
        int           len;
        logic [639:0] hdr;

        init_constants();
        sif.start = 1'b0;
        sif.abort = 1'b0;
        sif.header = '0;
        sif.nonce_start = '0;
        sif.nonce_end = '0;
        sif.target = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 256'(sif.busy), 256'd0);
        check("reset_found", 256'(sif.found), 256'd0);
        check("reset_exhausted", 256'(sif.exhausted), 256'd0);
        check("reset_attempts", 256'(sif.attempts), 256'd0);
        check("reset_nonce", 256'(sif.found_nonce), 256'd0);
        check("reset_hash", sif.found_hash, 256'd0);
        check("reset_lanes", 256'(sif.dbg_lane_run), 256'd0);
        rst = 1'b1;

        check("ref_sha_abc", compress(h0_init, {24'h616263, 1'b1, 423'b0, 64'd24}),
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        run_sweep(GENESIS, 32'h1dac2b7c, 32'h1dac2b7c, '1);
        run_sweep(GENESIS, 32'd0, 32'd9, '0);
        check("last_round_lanes", 256'(last_run), 256'(4'b0011));
        tgt = nonce_hash(GENESIS, 32'h15) + 256'd1;
        run_sweep(GENESIS, 32'h10, 32'h1b, tgt);
        run_sweep(GENESIS, 32'd5, 32'd4, '1);
        check("empty_range_latency", 256'(sweep_cycles), 256'd1);
        check("empty_range_lanes", 256'(lanes_ever), 256'd0);
        run_sweep(GENESIS, 32'hffff_fffe, 32'hffff_ffff, '0);
        check("top_range_lanes", 256'(last_run), 256'(4'b0011));

        for (int t = 0; t < 10; t++) begin
            hdr = rand_header();
            s = ($urandom_range(0, 1) == 1) ? $urandom : 32'hffff_ffff - 32'($urandom_range(0, 10));
            len = $urandom_range(0, 12);
            if (len == 0) begin
                if (s == 0) s = 32'd1;
                e = s - 32'd1;
            end else begin
                e_wide = {1'b0, s} + 33'(len) - 33'd1;
                e = e_wide[32] ? 32'hffff_ffff : e_wide[31:0];
            end
            run_sweep(hdr, s, e, rand_target());
        end

        pulse_start(GENESIS, 32'd0, 32'd100, '0);
        wait_state(S_RUN);
        repeat (20) @(posedge clk);
        #1;
        check("busy_mid_run", 256'(sif.busy), 256'd1);
        sif.abort = 1'b1;
        @(posedge clk); #1;
        sif.abort = 1'b0;
        check("abort_state", 256'(sif.dbg_state), 256'(S_IDLE));
        check("abort_busy", 256'(sif.busy), 256'd0);
        check("abort_flags", 256'({sif.found, sif.exhausted}), 256'd0);
        check("abort_lanes", 256'(sif.dbg_lane_run), 256'd0);

        run_sweep(rand_header(), 32'h100, 32'h103, '1);
        pulse_start(GENESIS, 32'd0, 32'd50, '0);
        wait_state(S_RUN);
        repeat (10) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("rst_busy", 256'(sif.busy), 256'd0);
        check("rst_flags", 256'({sif.found, sif.exhausted}), 256'd0);
        check("rst_nonce", 256'(sif.found_nonce), 256'd0);
        check("rst_hash", sif.found_hash, 256'd0);
        check("rst_attempts", 256'(sif.attempts), 256'd0);
        check("rst_lanes", 256'(sif.dbg_lane_run), 256'd0);
        check("rst_state", 256'(sif.dbg_state), 256'(S_IDLE));
        @(posedge clk); #1;
        rst = 1'b1;

        run_sweep(rand_header(), 32'h2000, 32'h2006, rand_target());
        check("queue_drained", 256'(exp_q.size()), 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
